decode_sb: RTL and testbench
============================

# decode_sb

Parametrised successor to the single-issue decode stage: decodes one RV32I instruction per cycle, reads a write-through register file, and interlocks RAW/WAW hazards with a per-register busy scoreboard instead of relying on a global stall. Sits between fetch and execute. Both sides use valid/ready handshakes, and the block supports flush. Later stages return one retire event per issued writing instruction; that event both writes the register file and releases the scoreboard entry.

## Interface
- XLEN, 32, datapath and register width
- NREGS, 32, architectural register count; x0 reads zero and is never busy
- AW, $clog2(NREGS), register index width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode accepts this cycle
- in_pc  in  XLEN  instruction PC
- in_instr  in  32  instruction word
- out_valid  out  1  decoded instruction held for execute
- out_ready  in  1  execute consumes this cycle
- out_pc, out_rs1_val, out_rs2_val, out_imm  out  XLEN each  PC, operands, selected sign-extended immediate
- out_rd  out  AW  destination index
- out_opcode / out_funct3 / out_funct7  out  7/3/7  raw fields
- out_wb_en  out  1  instruction writes rd (rd≠0)
- out_illegal  out  1  opcode not in RV32I base set
- flush  in  1  kill the held instruction and refuse input this cycle
- rt_valid  in  1  retire event
- rt_we  in  1  retire writes rt_data (0 = release only, for a killed instruction)
- rt_rd  in  AW  retiring destination
- rt_data  in  XLEN  write data
- sb_busy  out  NREGS  scoreboard state (debug/verification)

## Operation
- Usage by opcode:
  - LUI, AUIPC, JAL: write rd.
  - JALR, LOAD, OP-IMM: read rs1, write rd.
  - OP: read rs1 and rs2, write rd.
  - BRANCH, STORE: read rs1 and rs2, no rd.
  - Other opcodes: out_illegal=1; no reads, no writes.
- Immediate selection:
  - I for JALR/LOAD/OP-IMM, S for STORE, B for BRANCH, U for LUI/AUIPC, J for JAL.
  - 0 when illegal.
- Effective busy: busy_eff[r] = busy[r] and not (rt_valid and rt_rd==r).
- hazard = (uses_rs1 and busy_eff[rs1]) or (uses_rs2 and busy_eff[rs2]) or (wb_en and busy_eff[rd]).
- slot_free = !out_valid or out_ready.
- in_ready = slot_free and !hazard and !flush.
- Accept occurs when in_valid and in_ready:
  - Load the output register.
  - Set busy[rd] if wb_en.
- Retire: rt_valid clears busy[rt_rd]. If rt_we and rt_rd≠0, also write the register file.
- Same cycle as accept: a set of busy[rd] overrides a retire clear of the same index.
- Register read is write-through: a same-cycle rt write to rs1/rs2 supplies rt_data. Reads of x0 return 0.
- Flush:
  - out_valid←0.
  - If the held instruction had out_wb_en, clear its busy bit.
  - No accept this cycle. Retire still processed.
- rt_valid for an index that is not busy: clear is a no-op, write still occurs. This is a protocol error; it is not flagged.

## Timing
- Reset: all outputs, busy bits and all registers are 0; in_ready=0 during reset, then follows the equation.
- Latency: one cycle from accept to out_valid.
- Output fields stay stable while out_valid and !out_ready.
- in_ready depends combinationally on out_ready, flush, rt_* and in_instr. No skid buffer.
- Back-to-back issue every cycle when no hazards exist and out_ready=1.
- RAW on a retiring register issues in the same cycle as the retire (zero bubble).
- Async reset mid-operation drops the held instruction and all busy state immediately.

## Structure
- rv32i_types package additions:
  - opcode enum (reuse existing)
  - decode_out_t struct: pc, rs1_val, rs2_val, imm, rd, opcode, funct3, funct7, wb_en, illegal
  - usage-class function: returns uses_rs1/uses_rs2/wb_en from opcode
- Sub-module regfile_wt: NREGS×XLEN, two async read ports, one write port, write-through bypass, x0 zero, async reset.
- Scoreboard and output register live in decode_sb.

## Test plan
- Reset → all outputs 0, sb_busy=0. ADDI x1,x0,5 accepted → next cycle out_valid=1, out_imm=5, out_wb_en=1, sb_busy[1]=1.
- ADDI x1 held, then ADD x2,x1,x1 offered → in_ready=0 until rt_valid, rt_we, rt_rd=1, rt_data=5. That cycle in_ready=1; next cycle out_rs1_val=out_rs2_val=5.
- out_ready=0 for 3 cycles with out_valid=1 → outputs stable, in_ready=0. out_ready=1 → new instruction accepted same cycle.
- Held LW x3 with flush=1 → out_valid=0 next cycle, sb_busy[3]=0, nothing accepted that cycle.
- ADDI x0,x0,1 → out_wb_en=0, sb_busy unchanged. Opcode 7'b0000000 → out_illegal=1, out_imm=0.
- Retire rt_rd=4 with simultaneous accept of ADDI x4 (x4 busy) → accepted, sb_busy[4]=1 afterward.

Source files
------------

// File: rtl/decode_sb_pkg.sv
// decode_sb_pkg: shared RV32I decode types for the decode stage.
//   opcode_e      base-ISA major opcodes that the decoder accepts
//   imm_sel_e     immediate format selector
//   usage_t       per-opcode operand/destination usage class
//   usage_class() maps a raw opcode field to its usage class
//   imm_gen()     builds the sign-extended 32-bit immediate for a format
package decode_sb_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic     uses_rs1;
    logic     uses_rs2;
    logic     wr_rd;
    logic     legal;
    imm_sel_e imm_sel;
  } usage_t;

  function automatic usage_t usage_class(input logic [6:0] opc);
    usage_t u;
    u.uses_rs1 = 1'b0;
    u.uses_rs2 = 1'b0;
    u.wr_rd    = 1'b0;
    u.legal    = 1'b1;
    u.imm_sel  = IMM_NONE;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        u.wr_rd   = 1'b1;
        u.imm_sel = IMM_U;
      end
      OPC_JAL: begin
        u.wr_rd   = 1'b1;
        u.imm_sel = IMM_J;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        u.uses_rs1 = 1'b1;
        u.wr_rd    = 1'b1;
        u.imm_sel  = IMM_I;
      end
      OPC_OP: begin
        u.uses_rs1 = 1'b1;
        u.uses_rs2 = 1'b1;
        u.wr_rd    = 1'b1;
      end
      OPC_BRANCH: begin
        u.uses_rs1 = 1'b1;
        u.uses_rs2 = 1'b1;
        u.imm_sel  = IMM_B;
      end
      OPC_STORE: begin
        u.uses_rs1 = 1'b1;
        u.uses_rs2 = 1'b1;
        u.imm_sel  = IMM_S;
      end
      default: u.legal = 1'b0;
    endcase
    return u;
  endfunction

  function automatic logic [31:0] imm_gen(input imm_sel_e sel, input logic [31:0] ins);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_sb_regfile_wt.sv
// regfile_wt: NREGS x XLEN register file with write-through bypass.
//   clk, rst_n       clock, asynchronous active-low reset (clears all entries)
//   we/waddr/wdata   single write port; writes to index 0 are discarded
//   raddr1/rdata1    asynchronous read port 1
//   raddr2/rdata2    asynchronous read port 2
// A read of the index being written this cycle returns wdata; index 0 reads 0.
module regfile_wt #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic            wr_hit;

  assign wr_hit = we && (waddr != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_hit) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  always_comb begin
    if (raddr1 == '0)                 rdata1 = '0;
    else if (wr_hit && waddr == raddr1) rdata1 = wdata;
    else                              rdata1 = mem_q[raddr1];
  end

  always_comb begin
    if (raddr2 == '0)                 rdata2 = '0;
    else if (wr_hit && waddr == raddr2) rdata2 = wdata;
    else                              rdata2 = mem_q[raddr2];
  end

endmodule

// File: rtl/decode_sb.sv
// decode_sb: RV32I decode stage with per-register busy scoreboard.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     fetch handshake; in_pc, in_instr instruction payload
//   out_valid/out_ready   execute handshake; out_* decoded fields held in a
//                         single output register (no skid buffer)
//   flush                 kills the held instruction, blocks accept this cycle
//   rt_valid/rt_we/rt_rd/rt_data  retire event: releases busy[rt_rd] and
//                         optionally writes the register file
//   sb_busy               current scoreboard state
module decode_sb
  import decode_sb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_rs1_val,
  output logic [XLEN-1:0]  out_rs2_val,
  output logic [XLEN-1:0]  out_imm,
  output logic [AW-1:0]    out_rd,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic             out_wb_en,
  output logic             out_illegal,
  input  logic             flush,
  input  logic             rt_valid,
  input  logic             rt_we,
  input  logic [AW-1:0]    rt_rd,
  input  logic [XLEN-1:0]  rt_data,
  output logic [NREGS-1:0] sb_busy
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            wb_en;
    logic            illegal;
  } decode_out_t;

  decode_out_t      out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [NREGS-1:0] busy_q, busy_d, busy_eff;

  usage_t           use_c;
  logic [AW-1:0]    rs1, rs2, rd;
  logic             wb_en, hazard, slot_free, accept;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  rf_rd1, rf_rd2;

  assign use_c = usage_class(in_instr[6:0]);
  assign rs1   = in_instr[15 +: AW];
  assign rs2   = in_instr[20 +: AW];
  assign rd    = in_instr[7 +: AW];
  assign wb_en = use_c.wr_rd && (rd != '0);
  assign imm32 = imm_gen(use_c.imm_sel, in_instr);

  regfile_wt #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rt_valid && rt_we),
    .waddr  (rt_rd),
    .wdata  (rt_data),
    .raddr1 (rs1),
    .rdata1 (rf_rd1),
    .raddr2 (rs2),
    .rdata2 (rf_rd2)
  );

  // A register retiring this cycle no longer blocks, giving zero-bubble RAW.
  always_comb begin
    busy_eff = busy_q;
    if (rt_valid) busy_eff[rt_rd] = 1'b0;
  end

  assign hazard    = (use_c.uses_rs1 && busy_eff[rs1]) ||
                     (use_c.uses_rs2 && busy_eff[rs2]) ||
                     (wb_en && busy_eff[rd]);
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = rst_n && slot_free && !hazard && !flush;
  assign accept    = in_valid && in_ready;

  // Clears are applied before the accept set so that an accepting
  // instruction's busy bit wins over a same-index retire.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    if (rt_valid) busy_d[rt_rd] = 1'b0;
    if (flush) begin
      out_valid_d = 1'b0;
      if (out_valid_q && out_q.wb_en) busy_d[out_q.rd] = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_d.pc      = in_pc;
      out_d.rs1_val = use_c.uses_rs1 ? rf_rd1 : '0;
      out_d.rs2_val = use_c.uses_rs2 ? rf_rd2 : '0;
      out_d.imm     = XLEN'($signed(imm32));
      out_d.rd      = rd;
      out_d.opcode  = in_instr[6:0];
      out_d.funct3  = in_instr[14:12];
      out_d.funct7  = in_instr[31:25];
      out_d.wb_en   = wb_en;
      out_d.illegal = !use_c.legal;
      if (wb_en) busy_d[rd] = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_rs1_val = out_q.rs1_val;
  assign out_rs2_val = out_q.rs2_val;
  assign out_imm     = out_q.imm;
  assign out_rd      = out_q.rd;
  assign out_opcode  = out_q.opcode;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_wb_en   = out_q.wb_en;
  assign out_illegal = out_q.illegal;
  assign sb_busy     = busy_q;

endmodule

// File: tb/tb_decode_sb.sv
module tb_decode_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JAL    = 7'h6f;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] OPIMM  = 7'h13;
  localparam logic [6:0] OP     = 7'h33;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [31:0]      in_instr;
  logic             out_valid, out_ready;
  logic [XLEN-1:0]  out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [AW-1:0]    out_rd;
  logic [6:0]       out_opcode, out_funct7;
  logic [2:0]       out_funct3;
  logic             out_wb_en, out_illegal;
  logic             flush, rt_valid, rt_we;
  logic [AW-1:0]    rt_rd;
  logic [XLEN-1:0]  rt_data;
  logic [NREGS-1:0] sb_busy;

  always #5 clk = ~clk;

  decode_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_wb_en(out_wb_en), .out_illegal(out_illegal),
    .flush(flush), .rt_valid(rt_valid), .rt_we(rt_we), .rt_rd(rt_rd), .rt_data(rt_data),
    .sb_busy(sb_busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic        m_valid;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
  logic [4:0]  m_rd;
  logic [6:0]  m_opc, m_f7;
  logic [2:0]  m_f3;
  logic        m_wb, m_ill;
  logic [31:0] m_busy;
  logic [31:0] m_regs [32];

  function automatic void classify(input logic [6:0] op, output logic r1, output logic r2,
                                   output logic wr, output logic legal);
    r1 = 0; r2 = 0; wr = 0; legal = 1;
    case (op)
      LUI, AUIPC, JAL:     wr = 1;
      JALR, LOAD, OPIMM:   begin r1 = 1; wr = 1; end
      OP:                  begin r1 = 1; r2 = 1; wr = 1; end
      BRANCH, STORE:       begin r1 = 1; r2 = 1; end
      default:             legal = 0;
    endcase
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] ins);
    logic signed [31:0] s;
    s = ins;
    case (ins[6:0])
      JALR, LOAD, OPIMM: return 32'(s >>> 20);
      STORE:  return (32'(s >>> 20) & ~32'h1f) | ((ins >> 7) & 32'h1f);
      BRANCH: return (32'(s >>> 19) & 32'hfffff000) | ((ins << 4) & 32'h800) |
                     ((ins >> 20) & 32'h7e0) | ((ins >> 7) & 32'h1e);
      LUI, AUIPC: return ins & 32'hfffff000;
      JAL:    return (32'(s >>> 11) & 32'hfff00000) | (ins & 32'h000ff000) |
                     ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7fe);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (rt_valid && rt_we && rt_rd == r) return rt_data;
    return m_regs[r];
  endfunction

  always @(negedge clk) begin : compare
    logic        r1, r2, wr, lg, wbe, haz, exp_rdy;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] beff, nbusy;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_sb_busy", sb_busy, 0);
      m_valid = 0;
      m_busy  = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
    end else begin
      rs1 = in_instr[19:15];
      rs2 = in_instr[24:20];
      rd  = in_instr[11:7];
      classify(in_instr[6:0], r1, r2, wr, lg);
      wbe  = wr && rd != 0;
      beff = m_busy;
      if (rt_valid) beff[rt_rd] = 0;
      haz = (r1 && beff[rs1]) || (r2 && beff[rs2]) || (wbe && beff[rd]);
      exp_rdy = (!m_valid || out_ready) && !haz && !flush;

      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, m_valid);
      chk("sb_busy", sb_busy, m_busy);
      if (m_valid) begin
        chk("out_pc", out_pc, m_pc);
        chk("out_rs1_val", out_rs1_val, m_rs1);
        chk("out_rs2_val", out_rs2_val, m_rs2);
        chk("out_imm", out_imm, m_imm);
        chk("out_rd", out_rd, m_rd);
        chk("out_opcode", out_opcode, m_opc);
        chk("out_funct3", out_funct3, m_f3);
        chk("out_funct7", out_funct7, m_f7);
        chk("out_wb_en", out_wb_en, m_wb);
        chk("out_illegal", out_illegal, m_ill);
      end

      nbusy = m_busy;
      if (rt_valid) nbusy[rt_rd] = 0;
      if (flush) begin
        if (m_valid && m_wb) nbusy[m_rd] = 0;
        m_valid = 0;
      end else if (in_valid && exp_rdy) begin
        m_valid = 1;
        m_pc    = in_pc;
        m_rs1   = r1 ? model_read(rs1) : 32'h0;
        m_rs2   = r2 ? model_read(rs2) : 32'h0;
        m_imm   = model_imm(in_instr);
        m_rd    = rd;
        m_opc   = in_instr[6:0];
        m_f3    = in_instr[14:12];
        m_f7    = in_instr[31:25];
        m_wb    = wbe;
        m_ill   = !lg;
        if (wbe) nbusy[rd] = 1;
      end else if (out_ready) begin
        m_valid = 0;
      end
      nbusy[0] = 0;
      m_busy = nbusy;
      if (rt_valid && rt_we && rt_rd != 0) m_regs[rt_rd] = rt_data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rv, input logic rwe,
                       input logic [4:0] rrd, input logic [31:0] rdat);
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rt_valid  = rv;
    rt_we     = rwe;
    rt_rd     = rrd;
    rt_data   = rdat;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look;
    @(negedge clk);
    #1;
  endtask

  logic [6:0]  ops [11];
  logic [31:0] ins;
  int          busy_list [$];

  initial begin
    ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, 7'h00, 7'h7f};
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    look;
    chk("reset_out_pc", out_pc, 0);
    chk("reset_out_imm", out_imm, 0);
    tick;
    tick;
    rst_n = 1;
    look;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_sb_busy", sb_busy, 0);

    // ADDI x1,x0,5
    tick; drive(1, 32'h00500093, 32'h100, 0, 0, 0, 0, 0, 0);
    look; chk("addi_in_ready", in_ready, 1);
    // ADD x2,x1,x1 blocked by busy x1
    tick; drive(1, 32'h00108133, 32'h104, 1, 0, 0, 0, 0, 0);
    look;
    chk("addi_out_valid", out_valid, 1);
    chk("addi_out_imm", out_imm, 5);
    chk("addi_out_wb_en", out_wb_en, 1);
    chk("addi_busy1", sb_busy[1], 1);
    chk("raw_stall_0", in_ready, 0);
    tick; look;
    chk("raw_stall_1", in_ready, 0);
    tick; drive(1, 32'h00108133, 32'h104, 1, 0, 1, 1, 1, 5);
    look; chk("raw_retire_ready", in_ready, 1);
    // ADDI x5,x0,7 while execute stalls
    tick; drive(1, 32'h00700293, 32'h108, 0, 0, 0, 0, 0, 0);
    look;
    chk("add_rs1", out_rs1_val, 5);
    chk("add_rs2", out_rs2_val, 5);
    chk("stall_ready_0", in_ready, 0);
    for (int k = 1; k < 3; k++) begin
      tick; look;
      chk("stall_pc", out_pc, 32'h104);
      chk("stall_ready", in_ready, 0);
    end
    tick; drive(1, 32'h00700293, 32'h108, 1, 0, 0, 0, 0, 0);
    look; chk("unstall_ready", in_ready, 1);
    // LW x3,0(x0)
    tick; drive(1, 32'h00002183, 32'h10c, 1, 0, 0, 0, 0, 0);
    look;
    chk("x5_pc", out_pc, 32'h108);
    chk("x5_imm", out_imm, 7);
    // flush held LW, offering ADDI x6
    tick; drive(1, 32'h00100313, 32'h110, 0, 1, 0, 0, 0, 0);
    look;
    chk("lw_pc", out_pc, 32'h10c);
    chk("lw_busy3", sb_busy[3], 1);
    chk("flush_ready", in_ready, 0);
    tick; drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    look;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_busy3", sb_busy[3], 0);
    chk("flush_busy6", sb_busy[6], 0);
    // ADDI x0,x0,1 then illegal opcode
    tick; drive(1, 32'h00100013, 32'h114, 1, 0, 0, 0, 0, 0);
    look;
    tick; drive(1, 32'hfff00080, 32'h118, 1, 0, 0, 0, 0, 0);
    look;
    chk("x0_wb_en", out_wb_en, 0);
    chk("x0_busy", sb_busy, 32'h24);
    // ADDI x4,x0,1
    tick; drive(1, 32'h00100213, 32'h11c, 1, 0, 0, 0, 0, 0);
    look;
    chk("ill_illegal", out_illegal, 1);
    chk("ill_imm", out_imm, 0);
    chk("ill_wb_en", out_wb_en, 0);
    // ADDI x4,x0,2 alongside retire of x4
    tick; drive(1, 32'h00200213, 32'h120, 1, 0, 1, 1, 4, 9);
    look;
    chk("x4_busy_before", sb_busy[4], 1);
    chk("x4_retire_ready", in_ready, 1);
    tick; drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
    look;
    chk("x4_busy_after", sb_busy[4], 1);
    chk("x4_imm", out_imm, 2);
    chk("x4_pc", out_pc, 32'h120);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (c == 1500) rst_n = 0;
      if (c == 1503) rst_n = 1;
      ins        = $urandom;
      ins[6:0]   = ops[$urandom_range(10, 0)];
      ins[11:7]  = 5'($urandom_range(7, 0));
      ins[19:15] = 5'($urandom_range(7, 0));
      ins[24:20] = 5'($urandom_range(7, 0));
      in_valid   = ($urandom % 4) != 0;
      in_instr   = ins;
      in_pc      = $urandom & 32'hfffffffc;
      out_ready  = ($urandom % 4) != 0;
      flush      = ($urandom % 25) == 0;
      busy_list.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) busy_list.push_back(r);
      rt_we   = ($urandom % 8) != 0;
      rt_data = $urandom;
      if (busy_list.size() > 0 && ($urandom % 2) == 1) begin
        rt_valid = 1;
        rt_rd    = 5'(busy_list[$urandom_range(busy_list.size() - 1, 0)]);
      end else begin
        rt_valid = 0;
        rt_rd    = 5'($urandom);
      end
    end
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    look;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
